// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the two-port RAM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 32;

    // IDLE arbitrates round-robin; OWNx holds the RAM for a locked burst.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

endpackage : ram_arb_pkg

// File: rtl/ram_arb_rr2.sv
// 2-way round-robin pick with a last-served pointer register.
// Latency: pick is combinational; the pointer updates at the clock edge of a grant.
// Backpressure: none; the caller decides whether the pick is used.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   req0, req1       candidate requests
//   upd, upd_idx     a grant happened this cycle, and to which index
//   pick0, pick1     one-hot (or zero) round-robin choice
module ram_arb_rr2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic upd,
    input  logic upd_idx,
    output logic pick0,
    output logic pick1
);

    // Index of the requester served last. Resets to 1 so that requester 0
    // wins the first contested cycle.
    logic last_q;
    logic last_d;

    always_comb begin
        last_d = last_q;
        if (upd) begin
            last_d = upd_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    // A sole requester always wins; under contention the one not served last wins.
    assign pick0 = req0 & (~req1 | last_q);
    assign pick1 = req1 & (~req0 | ~last_q);

endmodule : ram_arb_rr2

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous RAM, with burst lock.
// Latency: grant is combinational in the request cycle; read data valid one cycle later.
// Backpressure: a requester holds its request until gnt is sampled high; a locked owner stalls the other.
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   reqN, rnwN, addrN, wdataN      request, read-not-write, word address, write data
//   lockN                          keep ownership of the RAM while asserted
//   gntN                           access accepted at this clock edge
//   rvalidN, rdata                 read data return (rdata shared, passes through from ram_dout)
//   ram_cs_b, ram_rnw, ram_addr,
//   ram_din, ram_dout              RAM port (active-low select, registered read data)
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              rnw0,
    input  logic              rnw1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_cs_b,
    output logic              ram_rnw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       rvalid0_q;
    logic       rvalid1_q;
    logic       pick0;
    logic       pick1;
    logic       g0;
    logic       g1;

    ram_arb_rr2 u_rr2 (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .req1    (req1),
        .upd     (g0 | g1),
        .upd_idx (g1),
        .pick0   (pick0),
        .pick1   (pick1)
    );

    // An owner keeps the RAM only while its lock is held; on the cycle its lock
    // drops, normal arbitration already applies, so the release costs no cycle.
    always_comb begin
        state_d = state_q;
        g0      = 1'b0;
        g1      = 1'b0;
        if (!reset) begin
            if (state_q == ST_OWN0 && lock0) begin
                g0 = req0;
            end else if (state_q == ST_OWN1 && lock1) begin
                g1 = req1;
            end else begin
                g0 = pick0;
                g1 = pick1;
                if (g0 && lock0) begin
                    state_d = ST_OWN0;
                end else if (g1 && lock1) begin
                    state_d = ST_OWN1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rvalid0_q <= g0 & rnw0;
            rvalid1_q <= g1 & rnw1;
        end
    end

    assign gnt0 = g0;
    assign gnt1 = g1;

    // Gating with reset kills a read that was granted just before reset rose.
    assign rvalid0 = rvalid0_q & ~reset;
    assign rvalid1 = rvalid1_q & ~reset;
    assign rdata   = ram_dout;

    assign ram_cs_b = ~(g0 | g1);
    assign ram_rnw  = g1 ? rnw1   : (g0 ? rnw0   : 1'b1);
    assign ram_addr = g1 ? addr1  : (g0 ? addr0  : '0);
    assign ram_din  = g1 ? wdata1 : (g0 ? wdata0 : '0);

endmodule : ram_arbiter
